// File: rtl/seven_segment_scanner.sv
// Multiplexed hex driver for NUM_DIGITS seven-segment digits: round-robin scan, per-digit decimal
// point, leading-zero blanking, PWM brightness and frame-aligned double-buffered data loading.
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLK_DIV        = 50000,
    parameter int unsigned BRIGHT_BITS    = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_zeros,
    input  logic [BRIGHT_BITS-1:0]    brightness,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int unsigned PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IW   = $clog2(NUM_DIGITS);
    localparam int unsigned STEP = CLK_DIV >> BRIGHT_BITS;

    localparam logic [PW-1:0]         PS_LAST  = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;

    logic [PW-1:0]            ps_q, ps_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]  stg_value_q, stg_value_d;
    logic [NUM_DIGITS-1:0]    stg_dp_q, stg_dp_d;
    logic                     stg_blank_q, stg_blank_d;
    logic                     pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0]  sh_value_q, sh_value_d;
    logic [NUM_DIGITS-1:0]    sh_dp_q, sh_dp_d;
    logic                     sh_blank_q, sh_blank_d;
    logic [6:0]               seg_q, seg_d;
    logic                     dp_q, dp_d;
    logic [NUM_DIGITS-1:0]    an_q, an_d;

    logic                     ps_last, wrap;
    logic [NUM_DIGITS-1:0]    lead_zero;
    logic [NUM_DIGITS-1:0]    onehot;
    logic [3:0]               nib;
    logic                     dp_sel, lz_sel, blank, lit_window;
    logic [6:0]               seg_raw;
    logic [31:0]              thr;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Slot prescaler and digit index
    always_comb begin
        ps_last = (ps_q == PS_LAST);
        wrap    = ps_last && (idx_q == IDX_LAST);
        ps_d    = ps_last ? '0 : ps_q + 1'b1;
        idx_d   = idx_q;
        if (ps_last) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Staging captures every load; shadow only changes at a frame wrap (or at once while dark),
    // so a load landing on the wrap cycle stays pending until the following wrap.
    always_comb begin
        stg_value_d = stg_value_q;
        stg_dp_d    = stg_dp_q;
        stg_blank_d = stg_blank_q;
        pend_d      = pend_q;
        sh_value_d  = sh_value_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        if (pend_q && (wrap || !en)) begin
            sh_value_d = stg_value_q;
            sh_dp_d    = stg_dp_q;
            sh_blank_d = stg_blank_q;
            pend_d     = 1'b0;
        end
        if (load) begin
            stg_value_d = value;
            stg_dp_d    = dp_in;
            stg_blank_d = blank_zeros;
            pend_d      = 1'b1;
        end
    end

    always_comb begin
        logic run;
        run = 1'b1;
        lead_zero = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            run = run && (sh_value_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
            lead_zero[NUM_DIGITS-1-k] = run;
        end
    end

    always_comb begin
        onehot = '0;
        nib    = 4'h0;
        dp_sel = 1'b0;
        lz_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                onehot[i] = 1'b1;
                nib       = sh_value_q[4*i +: 4];
                dp_sel    = sh_dp_q[i];
                lz_sel    = lead_zero[i];
            end
        end
        blank      = sh_blank_q && (idx_q != '0) && lz_sel;
        thr        = (32'(brightness) + 32'd1) * STEP;
        lit_window = en && (32'(ps_q) < thr);
        seg_raw    = blank ? 7'h00 : hex7(nib);
        seg_d      = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
        dp_d       = SEG_ACTIVE_LOW ? ~dp_sel : dp_sel;
        an_d       = lit_window ? onehot : '0;
        if (AN_ACTIVE_LOW) begin
            an_d = ~an_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q        <= '0;
            idx_q       <= '0;
            stg_value_q <= '0;
            stg_dp_q    <= '0;
            stg_blank_q <= 1'b0;
            pend_q      <= 1'b0;
            sh_value_q  <= '0;
            sh_dp_q     <= '0;
            sh_blank_q  <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            an_q        <= AN_OFF;
        end else begin
            ps_q        <= ps_d;
            idx_q       <= idx_d;
            stg_value_q <= stg_value_d;
            stg_dp_q    <= stg_dp_d;
            stg_blank_q <= stg_blank_d;
            pend_q      <= pend_d;
            sh_value_q  <= sh_value_d;
            sh_dp_q     <= sh_dp_d;
            sh_blank_q  <= sh_blank_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            an_q        <= an_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = wrap;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner (4 digits, 16-cycle slots, 2-bit brightness, active-low).
module tb_seven_segment_scanner;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        blank_zeros;
    logic [1:0]  brightness;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_done;

    seven_segment_scanner #(
        .NUM_DIGITS    (4),
        .CLK_DIV       (16),
        .BRIGHT_BITS   (2),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .value      (value),
        .dp_in      (dp_in),
        .blank_zeros(blank_zeros),
        .brightness (brightness),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [6:0] lit_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic to_frame_start();
        while (cyc % 64 != 0) step();
    endtask

    task automatic push_frame(input string tag, input logic [15:0] v, input logic [3:0] dpv,
                              input logic bz);
        exp_t        e;
        logic [15:0] upper;
        logic [3:0]  nib;
        for (int d = 0; d < 4; d++) begin
            nib   = v[4*d +: 4];
            upper = v >> (4 * d);
            e.tag = $sformatf("%s_d%0d", tag, d);
            e.seg = (bz && d > 0 && upper == 16'h0) ? 7'h7F : ~lit_tbl[nib];
            e.dp  = ~dpv[d];
            sb.push_back(e);
        end
    endtask

    // One full frame; expectations popped mid-slot. inject_at >= 0 pulses load on that cycle.
    task automatic check_frame(input int inject_at);
        exp_t       e;
        logic [3:0] oh;
        logic [3:0] exp_an;
        for (int i = 0; i < 64; i++) begin
            load = (i == inject_at);
            step();
            if (i % 16 == 8) begin
                oh     = 4'b0001 << (i / 16);
                exp_an = ~oh;
                if (sb.size() == 0) begin
                    check("sb_underflow", 16'd1, 16'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_seg"}, 16'(seg), 16'(e.seg));
                    check({e.tag, "_dp"}, 16'(dp), 16'(e.dp));
                    check({e.tag, "_an"}, 16'(an), 16'(exp_an));
                end
            end
        end
        load = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic bz);
        value       = v;
        dp_in       = dpv;
        blank_zeros = bz;
        load        = 1'b1;
        step();
        load        = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 16'(an), 16'h000F);
        check({tag, "_seg"}, 16'(seg), 16'h007F);
        check({tag, "_dp"}, 16'(dp), 16'h0001);
        check({tag, "_fd"}, 16'(frame_done), 16'h0000);
    endtask

    initial begin
        logic [3:0] oh;
        logic [3:0] exp_an;
        int         pulses;

        rst_n = 1'b0; en = 1'b1; load = 1'b0; value = '0; dp_in = '0;
        blank_zeros = 1'b0; brightness = 2'b11;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

        rst_n = 1'b1;
        cyc   = 0;
        step();
        check("first_an", 16'(an), 16'h000E);
        check("first_seg", 16'(seg), 16'h0040);
        check("first_dp", 16'(dp), 16'h0001);

        pulses = 0;
        while (cyc < 128) begin
            step();
            if (frame_done) pulses++;
            check($sformatf("fd_c%0d", cyc), 16'(frame_done), 16'((cyc % 64) == 63));
        end
        check("fd_pulses", 16'(pulses), 16'd2);

        // Inputs changed after the load must not leak into the display.
        do_load(16'h12AF, 4'b0100, 1'b0);
        value = 16'hFFFF; dp_in = 4'hF;
        to_frame_start();
        push_frame("hex", 16'h12AF, 4'b0100, 1'b0);
        check_frame(-1);

        do_load(16'h0050, 4'b0000, 1'b1);
        to_frame_start();
        push_frame("blank50", 16'h0050, 4'b0000, 1'b1);
        check_frame(-1);

        do_load(16'h0000, 4'b1000, 1'b1);
        to_frame_start();
        push_frame("blank0", 16'h0000, 4'b1000, 1'b1);
        check_frame(-1);

        value = 16'h3C9E; dp_in = 4'b0010; blank_zeros = 1'b0;
        push_frame("midold", 16'h0000, 4'b1000, 1'b1);
        check_frame(20);
        push_frame("midnew", 16'h3C9E, 4'b0010, 1'b0);
        check_frame(-1);

        repeat (63) step();
        do_load(16'h0B07, 4'b0000, 1'b1);
        push_frame("wrapold", 16'h3C9E, 4'b0010, 1'b0);
        check_frame(-1);
        push_frame("wrapnew", 16'h0B07, 4'b0000, 1'b1);
        check_frame(-1);

        for (int b = 0; b < 2; b++) begin
            brightness = 2'(b);
            for (int i = 0; i < 64; i++) begin
                step();
                oh     = 4'b0001 << (i / 16);
                exp_an = ((i % 16) < 4 * (b + 1)) ? ~oh : 4'hF;
                check($sformatf("bright%0d_c%0d_an", b, i), 16'(an), 16'(exp_an));
            end
        end
        brightness = 2'b11;

        en = 1'b0;
        value = 16'h00A0; dp_in = 4'b0010; blank_zeros = 1'b0;
        for (int i = 0; i < 64; i++) begin
            load = (i == 20);
            step();
            check($sformatf("dark_c%0d_an", i), 16'(an), 16'h000F);
            check($sformatf("dark_c%0d_fd", i), 16'(frame_done), 16'((cyc % 64) == 63));
            if (i == 21) begin
                check("dark_old_seg", 16'(seg), 16'h0040);
                check("dark_old_dp", 16'(dp), 16'h0001);
            end
            if (i == 22) begin
                check("dark_new_seg", 16'(seg), 16'h0008);
                check("dark_new_dp", 16'(dp), 16'h0000);
            end
        end
        load = 1'b0;
        en   = 1'b1;
        push_frame("afterdark", 16'h00A0, 4'b0010, 1'b0);
        check_frame(-1);

        repeat (40) step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset_hold");
        rst_n = 1'b1;
        cyc   = 0;
        push_frame("restart", 16'h0000, 4'b0000, 1'b0);
        check_frame(-1);

        check("sb_empty", 16'(sb.size()), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
